// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results go straight through, LSU loads queue in a FIFO; one registered write per cycle.
// ALU latency 1 cycle, LSU >= 2 cycles; both readies drop when the FIFO is full. Optional WB_FWD_EN adds combinational forwarding.
module wb_arbiter #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int XLEN       = 32,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int PW         = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic [4:0]      rd,
  output logic            rd_en,
  output logic [XLEN-1:0] rd_data,
  output logic [CW-1:0]   fifo_count,
`ifdef WB_FWD_EN
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data,
`endif
  output logic            busy
);

  logic [4:0]      mem_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic            full, empty, lsu_push, alu_fire, pop;

  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign alu_ready = reset && !full;
  assign lsu_ready = reset && !full;
  // x0 loads are handshaken but never stored
  assign lsu_push  = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign alu_fire  = alu_valid && alu_ready;
  assign pop       = full || (!alu_valid && !empty);
  assign busy      = (fifo_count != '0) || rd_en;

  always_ff @(posedge clk) begin
    if (lsu_push) begin
      mem_rd[wptr]   <= lsu_rd;
      mem_data[wptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      rd         <= '0;
      rd_en      <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (lsu_push) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      case ({lsu_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        rd      <= mem_rd[rptr];
        rd_data <= mem_data[rptr];
        rd_en   <= 1'b1;
      end else if (alu_fire) begin
        // writes to x0 are consumed without touching the held address/data
        rd_en <= (alu_rd != 5'd0);
        if (alu_rd != 5'd0) begin
          rd      <= alu_rd;
          rd_data <= alu_data;
        end
      end else begin
        rd_en <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  logic [PW-1:0] fidx;
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    fidx         = rptr;
    if (fwd_rs1 != 5'd0 && rd_en && rd == fwd_rs1) begin
      fwd_rs1_hit  = 1'b1;
      fwd_rs1_data = rd_data;
    end
    if (fwd_rs2 != 5'd0 && rd_en && rd == fwd_rs2) begin
      fwd_rs2_hit  = 1'b1;
      fwd_rs2_data = rd_data;
    end
    // walk oldest to youngest so the youngest matching entry wins
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fidx = rptr + PW'(i);
      if (CW'(i) < fifo_count) begin
        if (fwd_rs1 != 5'd0 && mem_rd[fidx] == fwd_rs1) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = mem_data[fidx];
        end
        if (fwd_rs2 != 5'd0 && mem_rd[fidx] == fwd_rs2) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = mem_data[fidx];
        end
      end
    end
  end
`endif

endmodule
